// File: rtl/dl_cmd_sched.sv
// Command scheduler: forwards host bytes to the driver and runs timed edge/unload sequences.
// Strobes are registered (host bytes appear one cycle after accept); host input stalls outside IDLE or on timer expiry.
module dl_cmd_sched #(
  parameter int P_SAMPLE_CYC = 24,
  parameter int P_UNLOADS    = 8,
  parameter int P_PERIOD_W   = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_host_valid,
  input  logic [7:0]            i_host_data,
  output logic                  o_host_ready,
  output logic                  o_cmd_valid,
  output logic [7:0]            o_cmd_data,
  input  logic                  i_tx_valid,
  input  logic                  i_tx_accept,
  input  logic                  i_cfg_en,
  input  logic [P_PERIOD_W-1:0] i_cfg_period,
  input  logic [3:0]            i_cfg_bursts,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int WAIT_W = (P_SAMPLE_CYC > 0) ? $clog2(P_SAMPLE_CYC + 1) : 1;
  localparam int UNL_W  = (P_UNLOADS > 0) ? $clog2(P_UNLOADS + 1) : 1;

  localparam logic [WAIT_W-1:0]     WAIT_INIT = WAIT_W'(P_SAMPLE_CYC);
  localparam logic [WAIT_W-1:0]     WAIT_ONE  = WAIT_W'(1);
  localparam logic [UNL_W-1:0]      UNL_INIT  = UNL_W'(P_UNLOADS);
  localparam logic [UNL_W-1:0]      UNL_ONE   = UNL_W'(1);
  localparam logic [P_PERIOD_W-1:0] TMR_ONE   = P_PERIOD_W'(1);
  localparam logic [7:0]            OP_EDGE   = 8'h03;
  localparam logic [7:0]            OP_UNLOAD = 8'h01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EDGE,
    S_WAIT,
    S_UNLOAD,
    S_DRAIN
  } state_e;

  state_e                  state_q, state_d;
  logic [P_PERIOD_W-1:0]   timer_q, timer_d;
  logic [WAIT_W-1:0]       wait_q, wait_d;
  logic [UNL_W-1:0]        unl_q, unl_d;
  logic [3:0]              burst_q, burst_d;
  logic                    inhibit_q, inhibit_d;
  logic                    en_q;
  logic                    cmd_valid_q, cmd_valid_d;
  logic [7:0]              cmd_data_q, cmd_data_d;
  logic                    done_q, done_d;

  logic en_rise, en_fall, expiry, host_acc, seq_done;

  assign en_rise = i_cfg_en & ~en_q;
  assign en_fall = ~i_cfg_en & en_q;

  // The rising-edge cycle only reloads the timer, so expiry needs en to have been high already.
  assign expiry   = (state_q == S_IDLE) & i_cfg_en & en_q & ~inhibit_q & (timer_q == '0);
  assign host_acc = i_host_valid & o_host_ready;

  assign o_host_ready = i_rst_n & (state_q == S_IDLE) & ~expiry;
  assign o_cmd_valid  = cmd_valid_q;
  assign o_cmd_data   = cmd_data_q;
  assign o_busy       = (state_q != S_IDLE);
  assign o_done       = done_q;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    wait_d      = wait_q;
    unl_d       = unl_q;
    burst_d     = burst_q;
    inhibit_d   = inhibit_q;
    cmd_valid_d = 1'b0;
    cmd_data_d  = cmd_data_q;
    done_d      = 1'b0;
    seq_done    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (expiry) begin
          state_d = S_EDGE;
        end else if (host_acc) begin
          cmd_valid_d = 1'b1;
          cmd_data_d  = i_host_data;
        end
        if (i_cfg_en && !inhibit_q && timer_q != '0) begin
          timer_d = timer_q - TMR_ONE;
        end
      end
      S_EDGE: begin
        wait_d  = WAIT_INIT;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wait_q != '0) begin
          wait_d = wait_q - WAIT_ONE;
        end
        if (wait_q <= WAIT_ONE) begin
          unl_d   = UNL_INIT;
          state_d = S_UNLOAD;
        end
      end
      S_UNLOAD: begin
        state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (i_tx_valid && i_tx_accept) begin
          if (unl_q > UNL_ONE) begin
            unl_d   = unl_q - UNL_ONE;
            state_d = S_UNLOAD;
          end else begin
            unl_d    = '0;
            seq_done = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (seq_done) begin
      state_d = S_IDLE;
      timer_d = i_cfg_period;
      burst_d = (burst_q == 4'hF) ? burst_q : burst_q + 4'd1;
      if (i_cfg_bursts != 4'd0 && burst_d == i_cfg_bursts) begin
        done_d    = 1'b1;
        inhibit_d = i_cfg_en;
      end
    end

    // Auto strobes are issued as the state is entered, so they line up with EDGE/UNLOAD.
    if (state_d == S_EDGE) begin
      cmd_valid_d = 1'b1;
      cmd_data_d  = OP_EDGE;
    end else if (state_d == S_UNLOAD) begin
      cmd_valid_d = 1'b1;
      cmd_data_d  = OP_UNLOAD;
    end

    if (en_rise) begin
      timer_d = i_cfg_period;
    end
    if (en_fall) begin
      burst_d   = 4'd0;
      inhibit_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      timer_q     <= i_cfg_period;
      wait_q      <= '0;
      unl_q       <= '0;
      burst_q     <= 4'd0;
      inhibit_q   <= 1'b0;
      en_q        <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_data_q  <= 8'h00;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      wait_q      <= wait_d;
      unl_q       <= unl_d;
      burst_q     <= burst_d;
      inhibit_q   <= inhibit_d;
      en_q        <= i_cfg_en;
      cmd_valid_q <= cmd_valid_d;
      cmd_data_q  <= cmd_data_d;
      done_q      <= done_d;
    end
  end

endmodule
